// File: rtl/multicycle_control_unit.sv
// Controller FSM for a shared-memory multicycle RISC-V datapath (lw, sw, R/I ALU ops, beq, jal).
// Memory states wait on mem_ready with a bounded timeout; illegal encodings and bus timeouts park in TRAP.
module multicycle_control_unit #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int MEM_TIMEOUT   = 16,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       imm_src,
    output logic [2:0]       alu_control,
    output logic             illegal_instr,
    output logic             bus_error,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instret
);

    localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    state_t             state_reg, state_next;
    logic [WC_W-1:0]    wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]   instret_reg;
    logic               illegal_reg, bus_error_reg;
    logic               set_illegal, set_bus_error, retire;
    logic               ready, timed_out, in_mem_state, f3_alu_legal;
    logic [2:0]         alu_dec;

    // With the handshake disabled memory is treated as always ready, so no wait or timeout can occur.
    assign ready     = (MEM_HANDSHAKE == 0) || mem_ready;
    assign timed_out = (MEM_HANDSHAKE != 0) && !mem_ready && (wait_cnt_reg == WC_LAST);
    assign in_mem_state = (state_reg == S_FETCH) || (state_reg == S_MEMREAD) ||
                          (state_reg == S_MEMWRITE);
    assign f3_alu_legal = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                          (funct3 == 3'b110) || (funct3 == 3'b111);

    always_comb begin
        unique case (funct3)
            3'b000:  alu_dec = (op[5] && funct7b5) ? 3'b011 : 3'b010;
            3'b010:  alu_dec = 3'b110;
            3'b110:  alu_dec = 3'b100;
            3'b111:  alu_dec = 3'b101;
            default: alu_dec = 3'b010;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        set_illegal   = 1'b0;
        set_bus_error = 1'b0;
        retire        = 1'b0;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        imm_src       = 2'b00;
        alu_control   = 3'b010;

        unique case (state_reg)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = ready;
                pc_write   = ready;
                if (ready) begin
                    state_next = S_DECODE;
                end else if (timed_out) begin
                    state_next    = S_TRAP;
                    set_bus_error = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                unique case (op)
                    OP_SW:   imm_src = 2'b01;
                    OP_BEQ:  imm_src = 2'b10;
                    OP_JAL:  imm_src = 2'b11;
                    default: imm_src = 2'b00;
                endcase
                if ((op == OP_LW || op == OP_SW) && funct3 == 3'b010)
                    state_next = S_MEMADR;
                else if (op == OP_R && f3_alu_legal && (!funct7b5 || funct3 == 3'b000))
                    state_next = S_EXECR;
                else if (op == OP_I && f3_alu_legal)
                    state_next = S_EXECI;
                else if (op == OP_BEQ && funct3 == 3'b000)
                    state_next = S_BEQ;
                else if (op == OP_JAL)
                    state_next = S_JAL;
                else begin
                    state_next  = S_TRAP;
                    set_illegal = 1'b1;
                end
            end
            S_MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                imm_src    = (op == OP_SW) ? 2'b01 : 2'b00;
                state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (ready) begin
                    state_next = S_MEMWB;
                end else if (timed_out) begin
                    state_next    = S_TRAP;
                    set_bus_error = 1'b1;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (ready) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end else if (timed_out) begin
                    state_next    = S_TRAP;
                    set_bus_error = 1'b1;
                end
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_dec;
                state_next  = S_ALUWB;
            end
            S_EXECI: begin
                // op[5]=0 for I-type, so the decoder never selects sub here.
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_dec;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_BEQ: begin
                alu_src_a   = 2'b10;
                alu_control = 3'b011;
                pc_write    = zero;
                state_next  = S_FETCH;
                retire      = 1'b1;
            end
            S_JAL: begin
                // ALUOut still holds the jump target computed during DECODE.
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_TRAP;
        endcase

        if (state_next != state_reg)
            wait_cnt_next = '0;
        else if (in_mem_state && !ready)
            wait_cnt_next = wait_cnt_reg + WC_W'(1);
        else
            wait_cnt_next = wait_cnt_reg;

        if (rst) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_FETCH;
            wait_cnt_reg  <= '0;
            instret_reg   <= '0;
            illegal_reg   <= 1'b0;
            bus_error_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (set_illegal)
                illegal_reg <= 1'b1;
            if (set_bus_error)
                bus_error_reg <= 1'b1;
            if (retire)
                instret_reg <= instret_reg + CNT_W'(1);
        end
    end

    assign illegal_instr = illegal_reg;
    assign bus_error     = bus_error_reg;
    assign state_o       = state_reg;
    assign instret       = instret_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for the multicycle controller: walks each instruction class, memory waits,
// timeout and illegal-instruction traps, and reset recovery.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]  alu_control;
    logic        illegal_instr, bus_error;
    logic [3:0]  state_o;
    logic [31:0] instret;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .MEM_HANDSHAKE(1),
        .MEM_TIMEOUT  (4),
        .CNT_W        (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_write    (mem_write),
        .adr_src      (adr_src),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .reg_write    (reg_write),
        .result_src   (result_src),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .imm_src      (imm_src),
        .alu_control  (alu_control),
        .illegal_instr(illegal_instr),
        .bus_error    (bus_error),
        .state_o      (state_o),
        .instret      (instret)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("ok   %-22s got=%0h", tag, got);
        end else begin
            $display("FAIL %-22s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs set afterwards apply to the following edge.
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b1;
        nxt();
        nxt();
        check("rst_mem_req_forced", mem_req, 0);
        check("rst_ir_write_forced", ir_write, 0);
        check("rst_state", state_o, 0);
        rst = 1'b0;
        #1;

        // add x3,x1,x2
        instr(7'b0110011, 3'b000, 1'b0);
        check("add_fetch_state", state_o, 0);
        check("add_fetch_mem_req", mem_req, 1);
        check("add_fetch_irw", ir_write, 1);
        check("add_fetch_pcw", pc_write, 1);
        check("add_fetch_srcb", alu_src_b, 2);
        check("add_fetch_res", result_src, 2);
        check("reset_instret", instret, 0);
        check("reset_flags", {illegal_instr, bus_error}, 0);
        nxt();
        check("add_decode", state_o, 1);
        check("add_decode_ab", {alu_src_a, alu_src_b}, 4'b0101);
        nxt();
        check("add_execr", state_o, 6);
        check("add_alu", alu_control, 3'b010);
        check("add_execr_regw", reg_write, 0);
        nxt();
        check("add_aluwb", state_o, 8);
        check("add_aluwb_regw", reg_write, 1);
        check("add_aluwb_res", result_src, 0);
        nxt();
        check("add_retired", instret, 1);

        // sub
        instr(7'b0110011, 3'b000, 1'b1);
        nxt(); nxt();
        check("sub_execr", state_o, 6);
        check("sub_alu", alu_control, 3'b011);
        nxt(); nxt();
        check("sub_retired", instret, 2);

        // addi with funct7b5 set must still add
        instr(7'b0010011, 3'b000, 1'b1);
        nxt(); nxt();
        check("addi_execi", state_o, 7);
        check("addi_alu", alu_control, 3'b010);
        check("addi_srcb", alu_src_b, 1);
        nxt(); nxt();
        check("addi_retired", instret, 3);

        // lw with three wait cycles in MEMREAD
        instr(7'b0000011, 3'b010, 1'b0);
        nxt();
        check("lw_decode_imm", imm_src, 0);
        nxt();
        check("lw_memadr", state_o, 2);
        nxt();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("lw_memread_wait", state_o, 3);
            nxt();
        end
        mem_ready = 1'b1;
        #1;
        check("lw_memread_last", state_o, 3);
        check("lw_memread_adr", {mem_req, adr_src}, 2'b11);
        nxt();
        check("lw_memwb", state_o, 4);
        check("lw_memwb_res", result_src, 1);
        check("lw_memwb_regw", reg_write, 1);
        nxt();
        check("lw_retired", instret, 4);

        // beq taken then not taken
        for (int t = 1; t >= 0; t--) begin
            instr(7'b1100011, 3'b000, 1'b0);
            zero = t[0];
            nxt();
            check("beq_decode_imm", imm_src, 2);
            nxt();
            check("beq_state", state_o, 9);
            check("beq_pcw", pc_write, 32'(t));
            check("beq_alu", alu_control, 3'b011);
            nxt();
            check("beq_back_fetch", state_o, 0);
            check("beq_retired", instret, 32'(6 - t));
        end
        zero = 1'b0;

        // jal
        instr(7'b1101111, 3'b000, 1'b0);
        nxt();
        check("jal_decode_imm", imm_src, 3);
        nxt();
        check("jal_state", state_o, 10);
        check("jal_pcw_ab", {pc_write, alu_src_a, alu_src_b}, 5'b10110);
        nxt();
        check("jal_aluwb", state_o, 8);
        nxt();
        check("jal_retired", instret, 7);

        // sw
        instr(7'b0100011, 3'b010, 1'b0);
        nxt(); nxt();
        check("sw_memadr_imm", imm_src, 1);
        nxt();
        check("sw_memwrite", state_o, 5);
        check("sw_mem_write", {mem_req, mem_write, adr_src}, 3'b111);
        nxt();
        check("sw_retired", instret, 8);

        // fetch ready on the last allowed cycle completes normally
        instr(7'b0110011, 3'b000, 1'b0);
        mem_ready = 1'b0;
        #1;
        check("fetch_wait_irw", ir_write, 0);
        nxt(); nxt(); nxt();
        check("fetch_wait_state", state_o, 0);
        mem_ready = 1'b1;
        #1;
        check("fetch_ready_last", ir_write, 1);
        nxt();
        check("fetch_ready_decode", state_o, 1);
        nxt(); nxt(); nxt();
        check("add2_retired", instret, 9);

        // fetch timeout after four idle cycles
        mem_ready = 1'b0;
        nxt(); nxt(); nxt();
        check("timeout_pre_state", state_o, 0);
        nxt();
        check("timeout_trap", state_o, 15);
        check("timeout_bus_error", bus_error, 1);
        check("timeout_no_illegal", illegal_instr, 0);
        check("timeout_mem_req", mem_req, 0);
        check("timeout_instret", instret, 9);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("timeout_rst_state", state_o, 0);
        check("timeout_rst_flag", bus_error, 0);
        check("timeout_rst_instret", instret, 0);

        // ecall-style opcode traps and stays
        instr(7'b1110011, 3'b000, 1'b0);
        nxt(); nxt();
        check("illegal_trap", state_o, 15);
        check("illegal_flag", illegal_instr, 1);
        for (int i = 0; i < 20; i++) nxt();
        check("illegal_held", state_o, 15);
        check("illegal_held_flag", {illegal_instr, bus_error}, 2'b10);
        check("illegal_enables", {mem_req, pc_write, ir_write, reg_write}, 0);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        #1;
        check("illegal_rst_state", state_o, 0);
        check("illegal_rst_flag", illegal_instr, 0);

        // slt with funct7b5 set is not a legal R-type encoding
        instr(7'b0110011, 3'b010, 1'b1);
        nxt(); nxt();
        check("rtype_f7_illegal", {state_o, illegal_instr}, 5'b11111);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
